// File: rtl/sram_controller_if.sv
// Request/response and SRAM-pin bundle for sram_controller.
// The slave modport is the controller's view; master is the bus-master plus SRAM-array side.
interface sram_controller_if #(
  parameter int AW        = 6,
  parameter int WORD_SIZE = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [AW-1:0]        req_addr;
  logic [WORD_SIZE-1:0] req_wdata;
  logic                 rsp_valid;
  logic [WORD_SIZE-1:0] rsp_rdata;
  logic [AW-1:0]        mem_addr;
  logic [WORD_SIZE-1:0] mem_data_out;
  logic [WORD_SIZE-1:0] mem_data_in;
  logic                 mem_cs_n;
  logic                 mem_we_n;
  logic                 mem_oe_n;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_data_in,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_addr, mem_data_out, mem_cs_n, mem_we_n, mem_oe_n
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_data_in,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_addr, mem_data_out, mem_cs_n, mem_we_n, mem_oe_n
  );
endinterface

// File: rtl/sram_controller.sv
// Synchronous initiator for the asynchronous ramchip SRAM: SETUP/ACCESS/HOLD strobe sequencing.
// Define SRAM_CTRL_STATS_EN to add saturating rd_count/wr_count outputs.
module sram_controller #(
  parameter int ADDRESS_SIZE = 64,
  parameter int WORD_SIZE    = 32,
  parameter int WAIT_CYCLES  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  sram_controller_if.slave bus
`ifdef SRAM_CTRL_STATS_EN
  ,
  output logic [15:0]      rd_count,
  output logic [15:0]      wr_count
`endif
);
  localparam int AW = $clog2(ADDRESS_SIZE);
  localparam logic [3:0]           WAIT_LOAD  = 4'(WAIT_CYCLES - 1);
  localparam logic [WORD_SIZE-1:0] RDATA_OOR  = '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic       op_we, op_inr;
  logic       accept, req_inr, last_access;
  logic       cs_n_nxt, we_n_nxt, oe_n_nxt, rsp_valid_nxt;
  logic       acc_we_n, acc_oe_n;

  assign bus.req_ready = (state == IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign req_inr       = ({{(32-AW){1'b0}}, bus.req_addr} < 32'(ADDRESS_SIZE));
  // Out-of-range operations keep every strobe parked high.
  assign acc_we_n      = !(op_inr && op_we);
  assign acc_oe_n      = !(op_inr && !op_we);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Strobe values are computed for the upcoming state so they can be registered.
  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    cs_n_nxt      = 1'b1;
    we_n_nxt      = 1'b1;
    oe_n_nxt      = 1'b1;
    rsp_valid_nxt = 1'b0;
    last_access   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SETUP;
          cs_n_nxt  = !req_inr;
        end
      end
      SETUP: begin
        state_nxt    = ACCESS;
        wait_cnt_nxt = WAIT_LOAD;
        cs_n_nxt     = !op_inr;
        we_n_nxt     = acc_we_n;
        oe_n_nxt     = acc_oe_n;
      end
      ACCESS: begin
        cs_n_nxt = !op_inr;
        if (wait_cnt == 4'd0) begin
          state_nxt     = HOLD;
          last_access   = 1'b1;
          rsp_valid_nxt = !op_we;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
          we_n_nxt     = acc_we_n;
          oe_n_nxt     = acc_oe_n;
        end
      end
      HOLD: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_we            <= 1'b0;
      op_inr           <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_data_out <= '0;
      bus.mem_cs_n     <= 1'b1;
      bus.mem_we_n     <= 1'b1;
      bus.mem_oe_n     <= 1'b1;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_rdata    <= '0;
    end else begin
      bus.mem_cs_n  <= cs_n_nxt;
      bus.mem_we_n  <= we_n_nxt;
      bus.mem_oe_n  <= oe_n_nxt;
      bus.rsp_valid <= rsp_valid_nxt;
      if (accept) begin
        op_we            <= bus.req_we;
        op_inr           <= req_inr;
        bus.mem_addr     <= bus.req_addr;
        bus.mem_data_out <= bus.req_wdata;
      end
      // Read data is sampled on the last edge that OE is still asserted.
      if (last_access && !op_we) begin
        bus.rsp_rdata <= op_inr ? bus.mem_data_in : RDATA_OOR;
      end
    end
  end

`ifdef SRAM_CTRL_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (last_access && op_inr) begin
      if (op_we) wr_count <= sat_inc(wr_count);
      else       rd_count <= sat_inc(rd_count);
    end
  end
`endif
endmodule
